sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//  Memory-side end of the CPU's asynchronous-style SRAM bus: answers the active-low
//  CE/OE/WE/UB/LB strobes the control unit emits for fetch and load/store.
//  Holds a DEPTH x 16 word array. Returns read data after a fixed latency.
//  Commits writes only once WE has been held for the required number of cycles.
//  Sits between the datapath (MAR/MDR) and on-chip RAM, replacing board SRAM.
// PARAMETERS
//  ADDR_W     10  word-address width; DEPTH = 2**ADDR_W
//  READ_LAT   1   edges from first sampled read strobe to Data_out valid (1..4)
//  WRITE_LAT  2   consecutive cycles of sampled WE low required to commit (1..4)
// PORTS
//  Clk         in   1       system clock; all state changes on rising edge
//  Reset       in   1       synchronous, active-high
//  Mem_CE      in   1       chip enable, active low
//  Mem_OE      in   1       output enable, active low
//  Mem_WE      in   1       write enable, active low
//  Mem_UB      in   1       upper byte lane [15:8] enable, active low
//  Mem_LB      in   1       lower byte lane [7:0] enable, active low
//  ADDR        in   ADDR_W  word address
//  Data_in     in   16      write data (from MDR)
//  Data_out    out  16      read data (to MDR); registered
//  Data_valid  out  1       Data_out matches mem[ADDR] for the current read
//  Wr_done     out  1       one-cycle pulse on the edge a write commits
//  Abort       out  1       one-cycle pulse: write released before commit
//  Conflict    out  1       one-cycle pulse: OE and WE sampled low together
// BEHAVIOUR
//  - Reset: state IDLE; Data_out=0, Data_valid=0, Wr_done=Abort=Conflict=0; counter=0.
//    Memory contents are not cleared. Reset during WRITE discards the write with no Abort.
//  - Decode, sampled each edge: RD = !CE & !OE & WE; WR = !CE & !WE (OE ignored).
//    !CE & !OE & !WE raises Conflict for that cycle and is treated as WR.
//  - States: IDLE, READ, RD_HOLD, WRITE, WR_HOLD.
//  - IDLE:
//      RD -> READ with cnt=1 and latched addr=ADDR.
//      WR -> WRITE with cnt=1 and latched addr=ADDR.
//      else stay in IDLE.
//  - READ:
//      If !RD -> IDLE and Data_valid=0.
//      If ADDR != latched addr -> restart with cnt=1 at the new address.
//      If cnt==READ_LAT on this edge -> Data_out<=mem[addr], Data_valid<=1, go to RD_HOLD.
//      Else cnt++.
//      With READ_LAT=1, data is valid in the second cycle of OE low.
//  - RD_HOLD:
//      Data_valid stays 1 while RD holds and ADDR is unchanged.
//      ADDR change -> Data_valid=0, go to READ with cnt=1.
//      !RD -> IDLE and Data_valid=0. Data_out keeps its last value.
//  - WRITE:
//      If !WR before commit -> Abort pulse, no memory change, go to IDLE.
//      If ADDR changes -> restart with cnt=1.
//      If cnt==WRITE_LAT -> commit and go to WR_HOLD; else cnt++.
//      Commit rule: mem[addr][15:8]<=Data_in[15:8] if !UB; mem[addr][7:0]<=Data_in[7:0] if !LB.
//      UB, LB and Data_in are sampled at the commit edge. Wr_done pulses one cycle.
//  - WR_HOLD: stays until !WR, then IDLE. A held WE never re-commits.
//  - After a commit, a read of the same address must return the new data. No bypass is needed.
//  - ADDR is used as-is; DEPTH = 2**ADDR_W, so there is no out-of-range case.
//  - The counter is sized ceil(log2(max(READ_LAT,WRITE_LAT))+1) and saturates at its limit.
// TESTING
//  - Reset, then hold CE=OE=0, WE=1, ADDR=0x005 for 2 cycles with mem[5]=0x1234 preloaded:
//    Data_valid=1 and Data_out=0x1234 in cycle 2, Data_valid=0 after OE rises.
//  - CE=WE=0, UB=LB=0, ADDR=0x010, Data_in=0xBEEF for 2 cycles: Wr_done pulses at the
//    2nd edge; a following read returns 0xBEEF.
//  - Byte lanes: mem[0x010]=0xBEEF; write 0x1200 with UB=0, LB=1: readback returns 0x12EF.
//  - WE low for 1 cycle only (WRITE_LAT=2) at ADDR=0x020: Abort pulses and mem[0x20] is unchanged.
//  - During RD_HOLD, change ADDR 0x005->0x006: Data_valid drops for 1 cycle, then shows mem[6].
//  - OE=WE=0 together: Conflict=1 and the write proceeds. Reset mid-WRITE: no commit, Abort=0.

Source files
------------

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//   Memory-side end of the CPU's SRAM-style bus. Decodes the active-low
//   CE/OE/WE/UB/LB strobes each rising edge and serves a DEPTH x 16 on-chip
//   word array. Reads return registered data after READ_LAT edges. Writes
//   commit only after WE has been sampled low for WRITE_LAT consecutive edges
//   at a stable address.
//
// Handshake / timing contract (all sampled on rising Clk):
//   RD = !CE & !OE & WE, WR = !CE & !WE (OE ignored; OE low as well raises
//   Conflict). A read is "accepted" on the first edge RD is seen; Data_valid
//   rises READ_LAT edges later and stays high while RD and ADDR hold. A write
//   commits on the edge where the WRITE_LAT-th consecutive WR sample at the
//   same ADDR is taken; Wr_done pulses for that one cycle. Releasing WR
//   before that edge pulses Abort and leaves memory untouched.
//
// Ports
//   Clk, Reset        clock, synchronous active-high reset
//   Mem_CE/OE/WE      chip / output / write enable, active low
//   Mem_UB/Mem_LB     byte-lane enables [15:8] / [7:0], active low
//   ADDR              word address
//   Data_in           write data
//   Data_out          registered read data
//   Data_valid        Data_out holds mem[ADDR] for the current read
//   Wr_done           one-cycle pulse on the commit edge
//   Abort             one-cycle pulse when a write is released early
//   Conflict          high for a cycle in which OE and WE were sampled low
//   dbg_state         current FSM state (IDLE=0, READ=1, RD_HOLD=2,
//                     WRITE=3, WR_HOLD=4)
// -----------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 1,
    parameter int WRITE_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       Data_in,
    output logic [15:0]       Data_out,
    output logic              Data_valid,
    output logic              Wr_done,
    output logic              Abort,
    output logic              Conflict,
    output logic [2:0]        dbg_state
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] READ_LAT_C  = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WRITE_LAT_C = CNT_W'(WRITE_LAT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_RD_HOLD = 3'd2,
        S_WRITE   = 3'd3,
        S_WR_HOLD = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       mem [DEPTH];

    logic              rd;
    logic              wr;
    logic              conflict;
    logic              addr_chg;
    logic [CNT_W-1:0]  wr_cnt_next;
    logic              commit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign rd        = !Mem_CE && !Mem_OE && Mem_WE;
    assign wr        = !Mem_CE && !Mem_WE;
    assign conflict  = !Mem_CE && !Mem_OE && !Mem_WE;
    assign addr_chg  = (ADDR != addr_q);
    assign dbg_state = state;

    // Number of consecutive WR samples at the current address, including the
    // one being taken on this edge. Starting a write or moving the address
    // restarts the count at one.
    always_comb begin
        wr_cnt_next = CNT_ONE;
        if (state == S_WRITE && !addr_chg) begin
            wr_cnt_next = sat_inc(cnt);
        end
    end

    // The commit target is always ADDR: in IDLE it is the new address, and in
    // WRITE it either equals addr_q or has just replaced it.
    assign commit = !Reset && wr &&
                    (state == S_IDLE || state == S_WRITE) &&
                    (wr_cnt_next >= WRITE_LAT_C);

    // Storage is never reset so it can map onto block RAM.
    always_ff @(posedge Clk) begin
        if (commit) begin
            if (!Mem_UB) mem[ADDR][15:8] <= Data_in[15:8];
            if (!Mem_LB) mem[ADDR][7:0]  <= Data_in[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            Data_out   <= '0;
            Data_valid <= 1'b0;
            Wr_done    <= 1'b0;
            Abort      <= 1'b0;
            Conflict   <= 1'b0;
        end else begin
            Wr_done  <= commit;
            Abort    <= 1'b0;
            Conflict <= conflict;

            case (state)
                S_IDLE: begin
                    if (rd) begin
                        state  <= S_READ;
                        cnt    <= CNT_ONE;
                        addr_q <= ADDR;
                    end else if (wr) begin
                        addr_q <= ADDR;
                        cnt    <= wr_cnt_next;
                        state  <= commit ? S_WR_HOLD : S_WRITE;
                    end
                end

                S_READ: begin
                    if (!rd) begin
                        state      <= S_IDLE;
                        cnt        <= '0;
                        Data_valid <= 1'b0;
                    end else if (addr_chg) begin
                        cnt    <= CNT_ONE;
                        addr_q <= ADDR;
                    end else if (cnt >= READ_LAT_C) begin
                        Data_out   <= mem[addr_q];
                        Data_valid <= 1'b1;
                        state      <= S_RD_HOLD;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end

                S_RD_HOLD: begin
                    // Data_out is left alone on exit so the last word stays visible.
                    if (!rd) begin
                        state      <= S_IDLE;
                        cnt        <= '0;
                        Data_valid <= 1'b0;
                    end else if (addr_chg) begin
                        Data_valid <= 1'b0;
                        state      <= S_READ;
                        cnt        <= CNT_ONE;
                        addr_q     <= ADDR;
                    end
                end

                S_WRITE: begin
                    if (!wr) begin
                        Abort <= 1'b1;
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        addr_q <= ADDR;
                        cnt    <= wr_cnt_next;
                        if (commit) begin
                            state <= S_WR_HOLD;
                        end
                    end
                end

                S_WR_HOLD: begin
                    // A held WE never commits twice; wait for release.
                    if (!wr) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//   Transaction-level bench for sram_responder. Reads and writes are issued as
//   whole bus transactions (strobes held for N cycles, then released); the
//   expected pulse pattern and read data follow from the latency rules and a
//   word-array model of memory.
// -----------------------------------------------------------------------------
module tb_sram_responder;

    localparam int ADDR_W    = 10;
    localparam int READ_LAT  = 1;
    localparam int WRITE_LAT = 2;

    // ---------------- clock / reset ----------------
    logic              Clk;
    logic              Reset;
    logic              Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
    logic [ADDR_W-1:0] ADDR;
    logic [15:0]       Data_in;
    logic [15:0]       Data_out;
    logic              Data_valid, Wr_done, Abort, Conflict;
    logic [2:0]        dbg_state;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    sram_responder #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Mem_CE    (Mem_CE),
        .Mem_OE    (Mem_OE),
        .Mem_WE    (Mem_WE),
        .Mem_UB    (Mem_UB),
        .Mem_LB    (Mem_LB),
        .ADDR      (ADDR),
        .Data_in   (Data_in),
        .Data_out  (Data_out),
        .Data_valid(Data_valid),
        .Wr_done   (Wr_done),
        .Abort     (Abort),
        .Conflict  (Conflict),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem[int];
    int          known_q[$];

    typedef struct {
        bit          is_write;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic        ub;
        logic        lb;
        int          hold;
        bit          exp_commit;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        Mem_UB = 1'b1; Mem_LB = 1'b1;
    endtask

    task automatic model_write(input logic [9:0] a, input logic [15:0] d,
                               input logic ub, input logic lb);
        logic [15:0] w;
        w = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
        if (!ub) w[15:8] = d[15:8];
        if (!lb) w[7:0]  = d[7:0];
        if (!model_mem.exists(int'(a))) known_q.push_back(int'(a));
        model_mem[int'(a)] = w;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input int hold,
                            input bit exp_commit, input bit oe_low);
        for (int e = 1; e <= hold; e++) begin
            Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = oe_low ? 1'b0 : 1'b1;
            Mem_UB = ub; Mem_LB = lb; ADDR = a; Data_in = d;
            tick();
            check($sformatf("wr_done a=%h e=%0d", a, e), 16'(Wr_done),
                  16'(exp_commit && e == WRITE_LAT));
            check($sformatf("wr_abort_low a=%h e=%0d", a, e), 16'(Abort), 16'h0);
            check($sformatf("wr_conflict a=%h e=%0d", a, e), 16'(Conflict), 16'(oe_low));
        end
        drive_idle();
        tick();
        check($sformatf("wr_release_abort a=%h", a), 16'(Abort), 16'(!exp_commit));
        check($sformatf("wr_release_done a=%h", a), 16'(Wr_done), 16'h0);
        if (hold >= WRITE_LAT) model_write(a, d, ub, lb);
    endtask

    task automatic do_read(input logic [9:0] a, input int hold, input logic [15:0] exp);
        logic [15:0] cur;
        cur = 16'h0;
        exp_q.push_back(exp);
        for (int e = 1; e <= hold; e++) begin
            Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
            Mem_UB = 1'b0; Mem_LB = 1'b0; ADDR = a;
            tick();
            if (e >= READ_LAT + 1) begin
                if (e == READ_LAT + 1) cur = exp_q.pop_front();
                check($sformatf("rd_valid a=%h e=%0d", a, e), 16'(Data_valid), 16'h1);
                check($sformatf("rd_data a=%h e=%0d", a, e), Data_out, cur);
            end else begin
                check($sformatf("rd_wait a=%h e=%0d", a, e), 16'(Data_valid), 16'h0);
            end
        end
        drive_idle();
        tick();
        check($sformatf("rd_release_valid a=%h", a), 16'(Data_valid), 16'h0);
        check($sformatf("rd_release_keep a=%h", a), Data_out, cur);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 2, 1'b1, 16'h0000};
        vecs[1]  = '{1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 2, 1'b0, 16'h1234};
        vecs[2]  = '{1'b1, 10'h010, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1, 16'h0000};
        vecs[3]  = '{1'b0, 10'h010, 16'h0000, 1'b0, 1'b0, 3, 1'b0, 16'hBEEF};
        vecs[4]  = '{1'b1, 10'h010, 16'h1200, 1'b0, 1'b1, 2, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 10'h010, 16'h0000, 1'b0, 1'b0, 2, 1'b0, 16'h12EF};
        vecs[6]  = '{1'b1, 10'h020, 16'hAAAA, 1'b0, 1'b0, 2, 1'b1, 16'h0000};
        vecs[7]  = '{1'b1, 10'h020, 16'h5555, 1'b0, 1'b0, 1, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 10'h020, 16'h0000, 1'b0, 1'b0, 2, 1'b0, 16'hAAAA};
        vecs[9]  = '{1'b1, 10'h006, 16'h0606, 1'b0, 1'b0, 3, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 10'h006, 16'hFF00, 1'b1, 1'b0, 2, 1'b1, 16'h0000};
        vecs[11] = '{1'b0, 10'h006, 16'h0000, 1'b0, 1'b0, 2, 1'b0, 16'h0600};

        drive_idle();
        ADDR    = '0;
        Data_in = '0;
        Reset   = 1'b1;
        tick();
        tick();
        check("reset_data_out", Data_out, 16'h0);
        check("reset_valid", 16'(Data_valid), 16'h0);
        check("reset_wr_done", 16'(Wr_done), 16'h0);
        check("reset_abort", 16'(Abort), 16'h0);
        check("reset_conflict", 16'(Conflict), 16'h0);
        Reset = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write)
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].ub, vecs[i].lb,
                         vecs[i].hold, vecs[i].exp_commit, 1'b0);
            else
                do_read(vecs[i].addr, vecs[i].hold, vecs[i].exp_rdata);
        end

        // Address change while data is being held: one cycle of invalid data
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = 10'h005;
        tick();
        check("hold_seq_wait", 16'(Data_valid), 16'h0);
        tick();
        check("hold_seq_valid5", 16'(Data_valid), 16'h1);
        check("hold_seq_data5", Data_out, 16'h1234);
        ADDR = 10'h006;
        tick();
        check("hold_seq_drop", 16'(Data_valid), 16'h0);
        tick();
        check("hold_seq_valid6", 16'(Data_valid), 16'h1);
        check("hold_seq_data6", Data_out, 16'h0600);
        drive_idle();
        tick();
        check("hold_seq_release", 16'(Data_valid), 16'h0);

        // OE and WE low together: flagged, write still goes through
        do_write(10'h030, 16'h3C3C, 1'b0, 1'b0, 2, 1'b1, 1'b1);
        do_read(10'h030, 2, 16'h3C3C);

        // Address moves mid-write: the count restarts at the new address
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Data_in = 16'h4444; ADDR = 10'h040;
        tick();
        check("addr_move_e1", 16'(Wr_done), 16'h0);
        ADDR = 10'h041;
        tick();
        check("addr_move_e2", 16'(Wr_done), 16'h0);
        tick();
        check("addr_move_e3", 16'(Wr_done), 16'h1);
        drive_idle();
        tick();
        check("addr_move_abort", 16'(Abort), 16'h0);
        model_write(10'h041, 16'h4444, 1'b0, 1'b0);
        do_read(10'h041, 2, 16'h4444);

        // Reset while a write is pending: discarded silently
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Data_in = 16'h9999; ADDR = 10'h020;
        tick();
        Reset = 1'b1;
        tick();
        check("rst_mid_wr_done", 16'(Wr_done), 16'h0);
        check("rst_mid_wr_abort", 16'(Abort), 16'h0);
        Reset = 1'b0;
        drive_idle();
        tick();
        check("rst_mid_wr_abort_after", 16'(Abort), 16'h0);
        check("rst_mid_wr_done_after", 16'(Wr_done), 16'h0);
        do_read(10'h020, 2, 16'hAAAA);

        // Randomized transactions against the word-array model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0 && known_q.size() > 0) begin
                int          idx;
                logic [9:0]  ra;
                idx = int'($urandom_range(0, known_q.size() - 1));
                ra  = 10'(known_q[idx]);
                do_read(ra, int'($urandom_range(READ_LAT + 1, 4)), model_mem[int'(ra)]);
            end else begin
                logic [9:0]  wa;
                logic [15:0] wd;
                logic        ub, lb;
                int          hold;
                wa   = 10'($urandom_range(0, 63));
                wd   = 16'($urandom);
                ub   = 1'($urandom_range(0, 1));
                lb   = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 4));
                if (!model_mem.exists(int'(wa))) begin
                    ub = 1'b0;
                    lb = 1'b0;
                end
                do_write(wa, wd, ub, lb, hold, hold >= WRITE_LAT,
                         1'($urandom_range(0, 3) == 0));
            end
        end

        check("scoreboard_drain", 16'(exp_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
